// File: rtl/prbs4_pkg.sv
// Shared definitions for the 4-bit PRBS checker.
//   PRBS_W  : sample width
//   state_e : checker FSM states (SEARCH / LOCKED)
//   succ()  : next sample of the 15-state pattern for a given sample
package prbs4_pkg;

  localparam int PRBS_W = 4;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Shift right by one, feeding s[1]^s[0] into the MSB. The all-zero word
  // maps to itself and is never part of the maximal-length cycle.
  function automatic logic [PRBS_W-1:0] succ(input logic [PRBS_W-1:0] s);
    return {s[1] ^ s[0], s[3], s[2], s[1]};
  endfunction

endpackage

// File: rtl/prbs4_step.sv
// Combinational single-step predictor for the 4-bit pattern.
//   cur : current sample
//   nxt : predicted successor of cur
module prbs4_step
  import prbs4_pkg::*;
(
  input  logic [PRBS_W-1:0] cur,
  output logic [PRBS_W-1:0] nxt
);

  assign nxt = succ(cur);

endmodule

// File: rtl/prbs4_checker.sv
// Lock/track checker for a 4-bit PRBS stream.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   in_valid  : qualifies in_data; low holds all state
//   in_data   : incoming sample
//   clear_err : synchronous clear of err_count (wins over an increment)
//   locked    : high while the FSM is LOCKED
//   err_pulse : one-cycle pulse per mismatched sample while LOCKED
//   err_count : saturating count of LOCKED mismatches
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PRBS_W-1:0] in_data,
  input  logic              clear_err,
  output logic              locked,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  // Threshold compares are done against (N-1) on the pre-increment count,
  // so the beat that completes the run takes the transition.
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_N - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_N - 1);

  state_e            state, state_nxt;
  logic [PRBS_W-1:0] ref_q, ref_nxt;
  logic              ref_vld, ref_vld_nxt;
  logic [3:0]        good_cnt, good_nxt;
  logic [3:0]        bad_cnt, bad_nxt;
  logic [7:0]        cnt_nxt;
  logic [PRBS_W-1:0] exp_s;
  logic              err_hit;
  logic              seed_hit;

  prbs4_step u_step (
    .cur (ref_q),
    .nxt (exp_s)
  );

  // Zero never matches: succ(0)=0, so an all-zero seed would otherwise
  // "match" a stuck-at-zero line.
  assign seed_hit = ref_vld && (in_data == exp_s) && (in_data != '0);

  always_comb begin
    state_nxt   = state;
    ref_nxt     = ref_q;
    ref_vld_nxt = ref_vld;
    good_nxt    = good_cnt;
    bad_nxt     = bad_cnt;
    err_hit     = 1'b0;
    if (in_valid) begin
      case (state)
        ST_SEARCH: begin
          ref_nxt     = in_data;
          ref_vld_nxt = 1'b1;
          if (seed_hit) begin
            if (good_cnt == LOCK_LAST) begin
              state_nxt = ST_LOCKED;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              good_nxt = good_cnt + 4'd1;
            end
          end else begin
            good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction advances from its own state, so a
          // corrupted sample is counted once and never poisons ref.
          ref_nxt = exp_s;
          if (in_data != exp_s) begin
            err_hit = 1'b1;
            if (bad_cnt == LOSS_LAST) begin
              state_nxt   = ST_SEARCH;
              good_nxt    = '0;
              bad_nxt     = '0;
              ref_nxt     = in_data;
              ref_vld_nxt = 1'b1;
            end else begin
              bad_nxt = bad_cnt + 4'd1;
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = err_count;
    if (clear_err)
      cnt_nxt = '0;
    else if (err_hit && err_count != 8'hFF)
      cnt_nxt = err_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      ref_q     <= '0;
      ref_vld   <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      ref_q     <= ref_nxt;
      ref_vld   <= ref_vld_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      locked    <= (state_nxt == ST_LOCKED);
      err_pulse <= err_hit;
      err_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_prbs4_checker.sv
module tb_prbs4_checker;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       clear_err = 1'b0;
  logic       locked, err_pulse;
  logic [7:0] err_count;

  prbs4_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // The full 15-entry cycle, worked out by hand from the successor rule.
  logic [3:0] tbl [15] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001,
                           4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010,
                           4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011};

  int chks = 0;
  int errs = 0;
  int gp   = 0;

  function automatic int nxt_of(input logic [3:0] s);
    for (int i = 0; i < 15; i++)
      if (tbl[i] == s) return int'(tbl[(i + 1) % 15]);
    return -1;
  endfunction

  // Model: SEARCH keeps a window of recent samples and locks once the
  // last LOCK_N+1 form a run in the table; LOCKED walks the table.
  bit         mvalid = 0;
  bit         mlocked, mpulse;
  int         mcnt, mbad, mexp;
  logic [3:0] hist [$];

  function automatic bit chain_ok();
    if (hist.size() < LOCK_N + 1) return 0;
    for (int j = hist.size() - LOCK_N - 1; j < hist.size() - 1; j++)
      if (nxt_of(hist[j]) != int'(hist[j + 1])) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1; mlocked = 0; mpulse = 0; mcnt = 0; mbad = 0; mexp = -1;
      hist.delete();
    end else begin
      mpulse = 0;
      if (in_valid) begin
        if (!mlocked) begin
          hist.push_back(in_data);
          if (hist.size() > LOCK_N + 1) void'(hist.pop_front());
          if (chain_ok()) begin
            mlocked = 1; mbad = 0; mexp = nxt_of(in_data); hist.delete();
          end
        end else begin
          if (int'(in_data) != mexp) begin
            mpulse = 1;
            if (mcnt < 255) mcnt++;
            mbad++;
            if (mbad == LOSS_N) begin
              mlocked = 0; mbad = 0; hist.delete(); hist.push_back(in_data);
            end
          end else mbad = 0;
          mexp = nxt_of(4'(mexp));
        end
      end
      if (clear_err) mcnt = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    chks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_locked", int'(locked), int'(mlocked));
      chk("m_pulse", int'(err_pulse), int'(mpulse));
      chk("m_count", int'(err_count), mcnt);
    end
  end

  task automatic step(input logic v, input logic [3:0] d, input logic c);
    in_valid = v; in_data = d; clear_err = c;
    @(negedge clk);
  endtask
  task automatic good();
    step(1'b1, tbl[gp], 1'b0); gp = (gp + 1) % 15;
  endtask
  task automatic bad(input logic [3:0] d, input logic c);
    step(1'b1, d, c); gp = (gp + 1) % 15;
  endtask

  initial begin
    // Reset, with valid/clear asserted to show reset priority
    rst = 1'b1;
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b1000, 1'b0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    chk("rst_count", int'(err_count), 0);
    rst = 1'b0;

    // Acquire: 0001,1000,0100,0010 not yet locked; 1001 locks
    gp = 0;
    for (int i = 0; i < 4; i++) good();
    chk("acq_not_yet", int'(locked), 0);
    good();
    chk("acq_locked", int'(locked), 1);
    chk("acq_count", int'(err_count), 0);

    // 1100 replaced by 1101, then correct 0110
    bad(4'b1101, 1'b0);
    chk("single_pulse", int'(err_pulse), 1);
    chk("single_count", int'(err_count), 1);
    good();
    chk("after_fix_pulse", int'(err_pulse), 0);
    chk("after_fix_locked", int'(locked), 1);

    // Ten idle cycles, then the correct successor
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b0);
    chk("gap_locked", int'(locked), 1);
    good();
    chk("gap_pulse", int'(err_pulse), 0);
    chk("gap_locked2", int'(locked), 1);

    // Clear, then three zero samples drop lock
    step(1'b0, 4'b0000, 1'b1);
    chk("clear_idle", int'(err_count), 0);
    bad(4'b0000, 1'b0);
    bad(4'b0000, 1'b0);
    chk("loss_held", int'(locked), 1);
    bad(4'b0000, 1'b0);
    chk("loss_count", int'(err_count), 3);
    chk("loss_locked", int'(locked), 0);
    // First good sample only reseeds ref; four matches then relock
    for (int i = 0; i < 4; i++) good();
    chk("relock_not_yet", int'(locked), 0);
    good();
    chk("relock", int'(locked), 1);

    // Saturation: alternate wrong/right so lock holds
    step(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 255; i++) begin
      bad(tbl[gp] ^ 4'h1, 1'b0);
      good();
    end
    chk("sat_255", int'(err_count), 255);
    bad(tbl[gp] ^ 4'h2, 1'b0);
    chk("sat_hold", int'(err_count), 255);
    chk("sat_locked", int'(locked), 1);
    good();
    bad(tbl[gp] ^ 4'h4, 1'b1);
    chk("clr_win_count", int'(err_count), 0);
    chk("clr_win_pulse", int'(err_pulse), 1);
    good();

    // Reset mid-lock with a pending error count
    bad(tbl[gp] ^ 4'h8, 1'b0);
    good();
    chk("pre_rst_count", int'(err_count), 1);
    rst = 1'b1;
    step(1'b1, tbl[gp], 1'b0);
    rst = 1'b0;
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_count", int'(err_count), 0);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 1'b0);
    chk("zero_no_lock", int'(locked), 0);
    // Fresh acquisition after reset needs a full run again
    for (int i = 0; i < 4; i++) good();
    chk("fresh_not_yet", int'(locked), 0);
    good();
    chk("fresh_lock", int'(locked), 1);

    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end
endmodule
